// File: rtl/mips_cpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path:
// sequencer states, opcode/funct values, write-back source selects.
package mips_cpu_pkg;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;
  typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT, DEST_R31} dest_sel_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [4:0]  REG_RA = 5'd31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

endpackage

// File: rtl/mips_cpu_decode.sv
// Combinational instruction classifier: maps opcode/funct/rt to the
// instruction class flags and destination-register selection.
module mips_cpu_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_jr,
  output logic       is_link,
  output dest_sel_t  dest_sel,
  output logic       illegal
);

  always_comb begin
    is_rtype  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    is_link   = 1'b0;
    dest_sel  = DEST_NONE;
    illegal   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            is_rtype = 1'b1;
            dest_sel = DEST_RD;
          end
          FN_JR:   is_jr = 1'b1;
          FN_JALR: begin
            is_jr    = 1'b1;
            is_link  = 1'b1;
            dest_sel = DEST_RD;
          end
          default: illegal = 1'b1;
        endcase
      end
      // bltzal/bgezal only write $31 when the ALU raises link
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: is_branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            is_branch = 1'b1;
            dest_sel  = DEST_R31;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump  = 1'b1;
        is_link  = 1'b1;
        dest_sel = DEST_R31;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dest_sel = DEST_RT;
      OP_LW: begin
        is_load  = 1'b1;
        dest_sel = DEST_RT;
      end
      OP_SW:   is_store = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_control.sv
// Multi-cycle FETCH/EXEC/MEM sequencer owning PC, delay slot and bus handshake.
// Define MIPS_CPU_ILLEGAL_HALT_EN to halt with fault on unrecognised instructions.
module mips_cpu_control
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic [31:0] eff_addr,
  input  logic        sig_branch,
  input  logic        link,
  output logic [5:0]  ALU_control,
  output logic [5:0]  opcode,
  output logic [4:0]  shamt,
  output logic [15:0] immediate,
  output logic [4:0]  rt_index,
  output logic [4:0]  rs_index,
  output logic        reg_write,
  output logic [4:0]  reg_waddr,
  output logic [1:0]  reg_wsel,
  output logic [31:0] link_addr,
  output logic        active,
  output logic [31:0] pc,
  output logic        fault
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] target_reg, target_next;
  logic        delay_pending_reg, delay_pending_next;

  logic        is_rtype, is_load, is_store, is_branch, is_jump, is_jr, is_link, illegal;
  dest_sel_t   dest_sel;
  logic [31:0] pc_plus4, pc_load, branch_offset;
  logic [4:0]  dest_index;
  logic        read_int, write_int, reg_write_int;
  logic        finish, taken, halt_illegal;

  mips_cpu_decode u_decode (
    .opcode    (instr_reg[31:26]),
    .funct     (instr_reg[5:0]),
    .rt        (instr_reg[20:16]),
    .is_rtype  (is_rtype),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_jr     (is_jr),
    .is_link   (is_link),
    .dest_sel  (dest_sel),
    .illegal   (illegal)
  );

  assign opcode        = instr_reg[31:26];
  assign rs_index      = instr_reg[25:21];
  assign rt_index      = instr_reg[20:16];
  assign immediate     = instr_reg[15:0];
  assign shamt         = instr_reg[10:6];
  assign ALU_control   = instr_reg[5:0];
  assign pc_plus4      = pc_reg + 32'd4;
  assign pc_load       = delay_pending_reg ? target_reg : pc_plus4;
  assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign link_addr     = pc_reg + 32'd8;

  always_comb begin
    case (dest_sel)
      DEST_RD:  dest_index = instr_reg[15:11];
      DEST_RT:  dest_index = instr_reg[20:16];
      DEST_R31: dest_index = REG_RA;
      default:  dest_index = 5'd0;
    endcase
  end

`ifdef MIPS_CPU_ILLEGAL_HALT_EN
  logic fault_reg, fault_next;
  assign halt_illegal = illegal;
  assign fault        = fault_reg;
`else
  assign halt_illegal = 1'b0;
  assign fault        = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    instr_next         = instr_reg;
    mem_addr_next      = mem_addr_reg;
    wdata_next         = wdata_reg;
    target_next        = target_reg;
    delay_pending_next = delay_pending_reg;
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
    fault_next         = fault_reg;
`endif
    read_int      = 1'b0;
    write_int     = 1'b0;
    reg_write_int = 1'b0;
    reg_waddr     = dest_index;
    reg_wsel      = WSEL_ALU;
    finish        = 1'b0;
    taken         = 1'b0;
    case (state_reg)
      FETCH: begin
        read_int = 1'b1;
        if (!waitrequest) begin
          instr_next = readdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        mem_addr_next = eff_addr;
        wdata_next    = rt_content;
        if (halt_illegal) begin
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
          fault_next = 1'b1;
`endif
          state_next = HALTED;
        end else begin
          if (is_link || (is_branch && dest_sel == DEST_R31 && link)) begin
            reg_write_int = 1'b1;
            reg_wsel      = WSEL_LINK;
          end else if (!illegal && (is_rtype || (dest_sel == DEST_RT && !is_load))) begin
            reg_write_int = 1'b1;
          end
          taken = is_jump || is_jr || (is_branch && sig_branch);
          if (is_load || is_store) state_next = MEM;
          else                     finish     = 1'b1;
        end
      end
      MEM: begin
        read_int  = is_load;
        write_int = is_store;
        if (!waitrequest) begin
          if (is_load) begin
            reg_write_int = 1'b1;
            reg_wsel      = WSEL_MEM;
          end
          finish = 1'b1;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = HALTED;
    endcase
    if (finish) begin
      pc_next            = pc_load;
      delay_pending_next = 1'b0;
      state_next         = (pc_load == 32'd0) ? HALTED : FETCH;
    end
    // A transfer inside a delay slot re-arms the slot, so the later target wins
    if (taken) begin
      delay_pending_next = 1'b1;
      if (is_jr)        target_next = rs_content;
      else if (is_jump) target_next = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
      else              target_next = pc_plus4 + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= FETCH;
      pc_reg            <= RESET_VECTOR;
      instr_reg         <= 32'd0;
      mem_addr_reg      <= 32'd0;
      wdata_reg         <= 32'd0;
      target_reg        <= 32'd0;
      delay_pending_reg <= 1'b0;
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
      fault_reg         <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      instr_reg         <= instr_next;
      mem_addr_reg      <= mem_addr_next;
      wdata_reg         <= wdata_next;
      target_reg        <= target_next;
      delay_pending_reg <= delay_pending_next;
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
      fault_reg         <= fault_next;
`endif
    end
  end

  // Strobes are masked during reset so an abandoned access drops immediately
  assign read      = read_int & ~reset;
  assign write     = write_int & ~reset;
  assign reg_write = reg_write_int & ~reset;
  assign address   = (state_reg == MEM) ? mem_addr_reg : pc_reg;
  assign writedata = wdata_reg;
  assign active    = (state_reg != HALTED);
  assign pc        = pc_reg;

endmodule

// File: tb/tb_mips_cpu_control.sv
// Testbench for mips_cpu_control: directed scenarios plus randomized
// instruction stream checked against an instruction-level PC/delay-slot model.
module tb_mips_cpu_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic [31:0] address, writedata, link_addr, pc;
  logic        read, write, reg_write, active, fault;
  logic [31:0] rs_content = 32'd0, rt_content = 32'd0, eff_addr = 32'd0;
  logic        sig_branch = 1'b0, link = 1'b0;
  logic [5:0]  ALU_control, opcode;
  logic [4:0]  shamt, rt_index, rs_index, reg_waddr;
  logic [15:0] immediate;
  logic [1:0]  reg_wsel;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  // instruction-level reference state
  logic [31:0] m_pc, m_tgt;
  logic        m_pend;

  logic [5:0] alu_fn [10] = '{6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};

  always #5 clk = ~clk;

  mips_cpu_control dut (
    .clk         (clk),
    .reset       (reset),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .rs_content  (rs_content),
    .rt_content  (rt_content),
    .eff_addr    (eff_addr),
    .sig_branch  (sig_branch),
    .link        (link),
    .ALU_control (ALU_control),
    .opcode      (opcode),
    .shamt       (shamt),
    .immediate   (immediate),
    .rt_index    (rt_index),
    .rs_index    (rs_index),
    .reg_write   (reg_write),
    .reg_waddr   (reg_waddr),
    .reg_wsel    (reg_wsel),
    .link_addr   (link_addr),
    .active      (active),
    .pc          (pc),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_active", 32'(active), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", pc, RV);
    reset = 1'b0;
    m_pc = RV;
    m_pend = 1'b0;
    m_tgt = 32'd0;
  endtask

  // mem_kind: 0 none, 1 load, 2 store
  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                           input logic br, input logic lk,
                           input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ea,
                           input logic we, input logic [4:0] wa, input logic [1:0] ws,
                           input int mem_kind, input logic tk, input logic [31:0] tgt);
    logic [31:0] next_pc;
    logic        exec_we;
    $display("[TB] pc=%h instr=%h fwait=%0d mwait=%0d", m_pc, ins, fwait, mwait);
    for (int i = 0; i <= fwait; i++) begin
      waitrequest = (i < fwait);
      readdata = (i < fwait) ? $urandom : ins;
      #1;
      check("fetch_read", 32'(read), 32'd1);
      check("fetch_addr", address, m_pc);
      check("fetch_write", 32'(write), 32'd0);
      check("fetch_reg_write", 32'(reg_write), 32'd0);
      @(posedge clk); #1;
    end
    waitrequest = 1'($urandom);
    sig_branch = br;
    link = lk;
    rs_content = rs;
    rt_content = rt;
    eff_addr = ea;
    #1;
    exec_we = we && (mem_kind == 0);
    check("exec_opcode", 32'(opcode), 32'(ins[31:26]));
    check("exec_funct", 32'(ALU_control), 32'(ins[5:0]));
    check("exec_shamt", 32'(shamt), 32'(ins[10:6]));
    check("exec_imm", 32'(immediate), 32'(ins[15:0]));
    check("exec_rt", 32'(rt_index), 32'(ins[20:16]));
    check("exec_rs", 32'(rs_index), 32'(ins[25:21]));
    check("exec_read", 32'(read), 32'd0);
    check("exec_write", 32'(write), 32'd0);
    check("exec_reg_write", 32'(reg_write), 32'(exec_we));
    if (exec_we) begin
      check("exec_waddr", 32'(reg_waddr), 32'(wa));
      check("exec_wsel", 32'(reg_wsel), 32'(ws));
      if (ws == 2'b10) check("exec_link_addr", link_addr, m_pc + 32'd8);
    end
    @(posedge clk); #1;
    rs_content = $urandom;
    rt_content = $urandom;
    eff_addr = $urandom;
    sig_branch = 1'($urandom);
    link = 1'b0;
    if (mem_kind != 0) begin
      for (int i = 0; i <= mwait; i++) begin
        waitrequest = (i < mwait);
        readdata = $urandom;
        #1;
        check("mem_read", 32'(read), 32'(mem_kind == 1));
        check("mem_write", 32'(write), 32'(mem_kind == 2));
        check("mem_addr", address, ea);
        if (mem_kind == 2) check("mem_writedata", writedata, rt);
        check("mem_reg_write", 32'(reg_write), 32'(mem_kind == 1 && i == mwait));
        if (mem_kind == 1 && i == mwait) begin
          check("mem_waddr", 32'(reg_waddr), 32'(wa));
          check("mem_wsel", 32'(reg_wsel), 32'(ws));
        end
        @(posedge clk); #1;
      end
    end
    next_pc = m_pend ? m_tgt : m_pc + 32'd4;
    m_pend = tk;
    if (tk) m_tgt = tgt;
    m_pc = next_pc;
    check("pc", pc, m_pc);
    check("active", 32'(active), 32'(m_pc != 32'd0));
    check("fault", 32'(fault), 32'd0);
  endtask

  initial begin
    int          cat, fw, mw;
    logic [31:0] ins, rs_v, rt_v, ea_v, tgt, pc4, simm;
    logic [4:0]  r_rs, r_rt, r_rd, wa;
    logic [15:0] imm;
    logic [1:0]  ws;
    logic        br, lk, we, tk;
    int          mk;

    do_reset();
    // addu, then lw with three wait states at 0x1000
    run_instr(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd3, 2'b00, 0, 1'b0, 32'd0);
    run_instr(enc_i(6'h23, 5'd4, 5'd5, 16'h0000), 0, 3, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_1000,
              1'b1, 5'd5, 2'b01, 1, 1'b0, 32'd0);
    run_instr(enc_i(6'h09, 5'd1, 5'd6, 16'h0010), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd6, 2'b00, 0, 1'b0, 32'd0);
    run_instr(enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h25), 1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd7, 2'b00, 0, 1'b0, 32'd0);
    // beq at BFC00010, then its delay slot
    run_instr(enc_i(6'h04, 5'd1, 5'd2, 16'h0004), 0, 0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b0, 5'd0, 2'b00, 0, 1'b1, 32'hBFC0_0024);
    run_instr(enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h21), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd8, 2'b00, 0, 1'b0, 32'd0);
    check("beq_next_pc", pc, 32'hBFC0_0024);

    for (int n = 0; n < 250; n++) begin
      r_rs = 5'($urandom); r_rt = 5'($urandom); r_rd = 5'($urandom);
      imm  = 16'($urandom);
      rs_v = $urandom; rt_v = $urandom; ea_v = $urandom & 32'hFFFF_FFFC;
      br = 1'($urandom); lk = 1'b0; we = 1'b0; wa = 5'd0; ws = 2'b00; mk = 0; tk = 1'b0; tgt = 32'd0;
      pc4 = m_pc + 32'd4;
      cat = m_pend ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 10));
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
      if (cat == 10) cat = 0;
`endif
      case (cat)
        0: begin ins = enc_r(r_rs, r_rt, r_rd, 5'($urandom), alu_fn[$urandom_range(0, 9)]); we = 1'b1; wa = r_rd; end
        1: begin ins = enc_i(6'(8 + $urandom_range(0, 7)), r_rs, r_rt, imm); we = 1'b1; wa = r_rt; end
        2: begin ins = enc_i(6'h23, r_rs, r_rt, imm); we = 1'b1; wa = r_rt; ws = 2'b01; mk = 1; end
        3: begin ins = enc_i(6'h2B, r_rs, r_rt, imm); mk = 2; end
        4, 5: begin
          imm  = 16'($urandom_range(0, 255)) - 16'd128;
          simm = 32'($signed(imm));
          tgt  = pc4 + simm * 32'd4;
          tk   = br;
          if (cat == 4) begin
            if ($urandom_range(0, 2) == 0) ins = {6'h01, r_rs, 5'($urandom_range(0, 1)), imm};
            else ins = enc_i(6'(4 + $urandom_range(0, 3)), r_rs, r_rt, imm);
          end else begin
            ins = {6'h01, r_rs, ($urandom_range(0, 1) == 0) ? 5'h10 : 5'h11, imm};
            lk  = 1'($urandom);
            if (lk) begin we = 1'b1; wa = 5'd31; ws = 2'b10; end
          end
        end
        6, 7: begin
          ins = {(cat == 6) ? 6'h02 : 6'h03, 26'($urandom)};
          tk  = 1'b1;
          tgt = {pc4[31:28], ins[25:0], 2'b00};
          if (cat == 7) begin we = 1'b1; wa = 5'd31; ws = 2'b10; end
        end
        8, 9: begin
          rs_v = 32'h0010_0000 + (32'($urandom_range(0, 4095)) << 2);
          ins  = enc_r(r_rs, 5'd0, (cat == 9) ? r_rd : 5'd0, 5'd0, (cat == 9) ? 6'h09 : 6'h08);
          tk   = 1'b1;
          tgt  = rs_v;
          if (cat == 9) begin we = 1'b1; wa = r_rd; ws = 2'b10; end
        end
        default: ins = {6'h3F, 26'($urandom)};
      endcase
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 3));
      run_instr(ins, fw, mw, br, lk, rs_v, rt_v, ea_v, we, wa, ws, mk, tk, tgt);
    end

    // reset during a stalled sw abandons the write
    $display("[TB] sw stalled then reset at pc=%h", m_pc);
    waitrequest = 1'b0;
    readdata = enc_i(6'h2B, 5'd1, 5'd2, 16'h0000);
    #1;
    check("sw_fetch_read", 32'(read), 32'd1);
    @(posedge clk); #1;
    rt_content = 32'hDEAD_BEEF;
    eff_addr = 32'h0000_2000;
    @(posedge clk); #1;
    waitrequest = 1'b1;
    #1;
    check("sw_stall_write", 32'(write), 32'd1);
    check("sw_stall_addr", address, 32'h0000_2000);
    check("sw_stall_data", writedata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("sw_stall_write2", 32'(write), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("sw_rst_write", 32'(write), 32'd0);
    check("sw_rst_read", 32'(read), 32'd0);
    check("sw_rst_reg_write", 32'(reg_write), 32'd0);
    check("sw_rst_pc", pc, RV);
    reset = 1'b0;
    waitrequest = 1'b0;
    m_pc = RV;
    m_pend = 1'b0;

    // jal, delay slot, jr $0, delay slot -> halt
    run_instr({6'h03, 26'h000_0100}, 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd31, 2'b10, 0, 1'b1, 32'hB000_0400);
    run_instr(enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h21), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd9, 2'b00, 0, 1'b0, 32'd0);
    check("jal_target_pc", pc, 32'hB000_0400);
    run_instr(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b0, 5'd0, 2'b00, 0, 1'b1, 32'd0);
    run_instr(enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h21), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd10, 2'b00, 0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      waitrequest = 1'($urandom);
      #1;
      check("halt_read", 32'(read), 32'd0);
      check("halt_write", 32'(write), 32'd0);
      check("halt_reg_write", 32'(reg_write), 32'd0);
      check("halt_active", 32'(active), 32'd0);
      @(posedge clk); #1;
    end

    // opcode 6'h3F
    do_reset();
`ifdef MIPS_CPU_ILLEGAL_HALT_EN
    $display("[TB] illegal opcode 3F at pc=%h (halt build)", m_pc);
    waitrequest = 1'b0;
    readdata = 32'hFC00_1234;
    @(posedge clk); #1;
    #1;
    check("ill_reg_write", 32'(reg_write), 32'd0);
    @(posedge clk); #1;
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_active", 32'(active), 32'd0);
    check("ill_read", 32'(read), 32'd0);
`else
    run_instr(32'hFC00_1234, 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b0, 5'd0, 2'b00, 0, 1'b0, 32'd0);
    check("ill_nop_pc", pc, 32'hBFC0_0004);
    run_instr(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
              1'b1, 5'd3, 2'b00, 0, 1'b0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
